// File: rtl/e_muldiv_unit_if.sv
// Execute-stage bus between the pipeline and the HI/LO multiply/divide unit.
// The pipeline drives the decoded E-stage fields; the unit answers with stall, read data and HI/LO.
interface e_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       E_op;
  logic [5:0]       E_func;
  logic [WIDTH-1:0] E_valA;
  logic [WIDTH-1:0] E_valB;
  logic             E_hold;
  logic             E_md_stall;
  logic [WIDTH-1:0] E_md_result;
  logic             md_busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output E_op, E_func, E_valA, E_valB, E_hold,
    input  E_md_stall, E_md_result, md_busy, HI, LO
  );

  modport slave (
    input  E_op, E_func, E_valA, E_valB, E_hold,
    output E_md_stall, E_md_result, md_busy, HI, LO
  );
endinterface

// File: rtl/e_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle on magnitudes, followed by a single sign fix-up cycle that writes HI/LO.
module e_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  e_muldiv_unit_if.slave  md
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

  function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] negW2(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] absW(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? negW(v) : v;
  endfunction

  state_t             state_r, next_s;
  logic [CW-1:0]      cnt_r;
  // Upper half: partial product / remainder. Lower half: multiplier / quotient.
  logic [2*WIDTH-1:0] work_r;
  logic [WIDTH-1:0]   other_r, rawA_r, hi_r, lo_r;
  logic               negProd_r, negRem_r, divZero_r, isDivOp_r;

  logic isMd_s, isMt_s, isMul_s, isDiv_s, isSigned_s, start_s;
  logic [WIDTH:0]       mulSum_s, divShift_s, divDiff_s;
  logic [2*WIDTH-1:0]   mulNext_s, divNext_s, prodFix_s;
  logic [WIDTH-1:0]     fixHi_s, fixLo_s, opA_s, opB_s, result_s;

  // Instruction decode of the E-stage fields
  always_comb begin
    isMd_s = 1'b0; isMt_s = 1'b0; isMul_s = 1'b0; isDiv_s = 1'b0; isSigned_s = 1'b0;
    if (md.E_op == OP_SPECIAL) begin
      case (md.E_func)
        FN_MFHI, FN_MFLO: isMd_s = 1'b1;
        FN_MTHI, FN_MTLO: begin isMd_s = 1'b1; isMt_s = 1'b1; end
        FN_MULT:  begin isMd_s = 1'b1; isMul_s = 1'b1; isSigned_s = 1'b1; end
        FN_MULTU: begin isMd_s = 1'b1; isMul_s = 1'b1; end
        FN_DIV:   begin isMd_s = 1'b1; isDiv_s = 1'b1; isSigned_s = 1'b1; end
        FN_DIVU:  begin isMd_s = 1'b1; isDiv_s = 1'b1; end
        default:  isMd_s = 1'b0;
      endcase
    end else begin
      isMd_s = 1'b0;
    end
  end

  assign start_s = (isMul_s | isDiv_s) & ~md.E_hold & (state_r == IDLE);
  assign opA_s   = isSigned_s ? absW(md.E_valA) : md.E_valA;
  assign opB_s   = isSigned_s ? absW(md.E_valB) : md.E_valB;

  // One iteration step of each algorithm plus the final sign correction
  always_comb begin
    mulSum_s   = {1'b0, work_r[2*WIDTH-1:WIDTH]} + (work_r[0] ? {1'b0, other_r} : {(WIDTH+1){1'b0}});
    mulNext_s  = {mulSum_s, work_r[WIDTH-1:1]};
    divShift_s = work_r[2*WIDTH-1:WIDTH-1];
    divDiff_s  = divShift_s - {1'b0, other_r};
    if (divDiff_s[WIDTH]) begin
      divNext_s = {divShift_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
    end else begin
      divNext_s = {divDiff_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
    end
    prodFix_s = negProd_r ? negW2(work_r) : work_r;
    fixHi_s   = prodFix_s[2*WIDTH-1:WIDTH];
    fixLo_s   = prodFix_s[WIDTH-1:0];
    if (isDivOp_r && divZero_r) begin
      fixHi_s = rawA_r;
      fixLo_s = {WIDTH{1'b1}};
    end else if (isDivOp_r) begin
      fixLo_s = negProd_r ? negW(work_r[WIDTH-1:0]) : work_r[WIDTH-1:0];
      fixHi_s = negRem_r ? negW(work_r[2*WIDTH-1:WIDTH]) : work_r[2*WIDTH-1:WIDTH];
    end else begin
      fixHi_s = prodFix_s[2*WIDTH-1:WIDTH];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= next_s;
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) next_s = isMul_s ? MUL : DIV;
        else         next_s = IDLE;
      end
      MUL: begin
        if (cnt_r == LAST_CNT) next_s = FIX;
        else                   next_s = MUL;
      end
      DIV: begin
        if (cnt_r == LAST_CNT) next_s = FIX;
        else                   next_s = DIV;
      end
      FIX:     next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and HI/LO write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0; work_r <= '0; other_r <= '0; rawA_r <= '0;
      hi_r <= '0; lo_r <= '0;
      negProd_r <= 1'b0; negRem_r <= 1'b0; divZero_r <= 1'b0; isDivOp_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (start_s) begin
            work_r    <= {{WIDTH{1'b0}}, opA_s};
            other_r   <= opB_s;
            rawA_r    <= md.E_valA;
            negProd_r <= isSigned_s & (md.E_valA[WIDTH-1] ^ md.E_valB[WIDTH-1]);
            negRem_r  <= isSigned_s & md.E_valA[WIDTH-1];
            divZero_r <= isDiv_s & (md.E_valB == {WIDTH{1'b0}});
            isDivOp_r <= isDiv_s;
          end else if (isMt_s && !md.E_hold) begin
            if (md.E_func == FN_MTHI) hi_r <= md.E_valA;
            else                      lo_r <= md.E_valA;
          end
        end
        MUL: begin
          work_r <= mulNext_s;
          cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        DIV: begin
          work_r <= divNext_s;
          cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        FIX: begin
          hi_r  <= fixHi_s;
          lo_r  <= fixLo_s;
          cnt_r <= '0;
        end
        default: cnt_r <= '0;
      endcase
    end
  end

  // MFHI/MFLO read port
  always_comb begin
    result_s = '0;
    if (md.E_op == OP_SPECIAL && md.E_func == FN_MFHI)      result_s = hi_r;
    else if (md.E_op == OP_SPECIAL && md.E_func == FN_MFLO) result_s = lo_r;
    else                                                    result_s = '0;
  end

  assign md.md_busy     = (state_r != IDLE);
  assign md.E_md_stall  = md.md_busy & isMd_s;
  assign md.E_md_result = result_s;
  assign md.HI          = hi_r;
  assign md.LO          = lo_r;
endmodule

// File: tb/tb_e_muldiv_unit.sv
// Self-checking bench for e_muldiv_unit: directed corner cases plus randomized
// MULT/MULTU/DIV/DIVU traffic checked against a plain-arithmetic HI/LO model.
module tb_e_muldiv_unit;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD = 6'h20;

  logic clk;
  logic rst_n;
  int   nCompared;
  int   nMismatched;

  e_muldiv_unit_if #(.WIDTH(32)) mdIf ();

  e_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (mdIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {HI, LO} from the architectural definition using wide integer arithmetic.
  function automatic logic [63:0] refOp(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (fn)
      F_MULT:  return 64'(sa * sb);
      F_MULTU: return {32'h0, a} * {32'h0, b};
      F_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        q = sa / sb; r = sa % sb;
        qv = q; rv = r;
        return {rv[31:0], qv[31:0]};
      end
      F_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic setIns(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, input logic hold);
    mdIf.E_op   = 6'h00;
    mdIf.E_func = fn;
    mdIf.E_valA = a;
    mdIf.E_valB = b;
    mdIf.E_hold = hold;
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Issue one md op, count the busy window and check HI/LO afterwards.
  task automatic runMd(input string tag, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] expHiLo);
    int cyc;
    setIns(fn, a, b, 1'b0);
    #1;
    checkVal({tag, "_selfstall"}, 64'(mdIf.E_md_stall), 64'h0);
    stepClk();
    setIns(F_ADD, 32'h0, 32'h0, 1'b0);
    cyc = 0;
    while (mdIf.md_busy && cyc < 100) begin
      cyc++;
      stepClk();
    end
    checkVal({tag, "_busycyc"}, 64'(cyc), 64'd33);
    checkVal({tag, "_hilo"}, {mdIf.HI, mdIf.LO}, expHiLo);
  endtask

  task automatic readBack(input string tag, input logic [63:0] expHiLo);
    setIns(F_MFHI, 32'h0, 32'h0, 1'b0);
    #1;
    checkVal({tag, "_mfhi"}, 64'(mdIf.E_md_result), 64'(expHiLo[63:32]));
    setIns(F_MFLO, 32'h0, 32'h0, 1'b0);
    #1;
    checkVal({tag, "_mflo"}, 64'(mdIf.E_md_result), 64'(expHiLo[31:0]));
    setIns(F_ADD, 32'h0, 32'h0, 1'b0);
    #1;
  endtask

  initial begin
    logic [63:0] exp;
    logic [5:0]  fn;
    logic [31:0] a, b;
    int cyc;
    logic [5:0] fnTab [4];
    nCompared = 0;
    nMismatched = 0;
    fnTab[0] = F_MULT; fnTab[1] = F_MULTU; fnTab[2] = F_DIV; fnTab[3] = F_DIVU;

    rst_n = 1'b0;
    setIns(F_ADD, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst_busy", 64'(mdIf.md_busy), 64'h0);
    checkVal("rst_hilo", {mdIf.HI, mdIf.LO}, 64'h0);
    checkVal("rst_stall", 64'(mdIf.E_md_stall), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stepClk();

    // Directed corner cases with hand-derived results
    runMd("mult_neg",   F_MULT,  32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1);
    readBack("mult_neg", 64'hFFFFFFFF_FFFFFFF1);
    runMd("multu_max",  F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    runMd("div_neg",    F_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD);
    runMd("divu_zero",  F_DIVU,  32'd7,        32'd0,        64'h00000007_FFFFFFFF);
    runMd("div_zero",   F_DIV,   32'hFFFFFFF9, 32'd0,        64'hFFFFFFF9_FFFFFFFF);
    runMd("div_ovf",    F_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    runMd("div_remneg", F_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003);

    // MULT immediately followed by MFLO: stall for the whole busy window
    a = $urandom; b = $urandom;
    exp = refOp(F_MULT, a, b);
    setIns(F_MULT, a, b, 1'b0);
    stepClk();
    setIns(F_MFLO, 32'h0, 32'h0, 1'b0);
    #1;
    cyc = 0;
    while (mdIf.E_md_stall && cyc < 100) begin
      cyc++;
      stepClk();
    end
    checkVal("mflo_stallcyc", 64'(cyc), 64'd33);
    checkVal("mflo_busy_after", 64'(mdIf.md_busy), 64'h0);
    checkVal("mflo_result", 64'(mdIf.E_md_result), 64'(exp[31:0]));

    // Non-md instruction between MULT and MFLO proceeds while busy
    a = $urandom; b = $urandom;
    exp = refOp(F_MULTU, a, b);
    setIns(F_MULTU, a, b, 1'b0);
    stepClk();
    setIns(F_ADD, 32'h0, 32'h0, 1'b0);
    #1;
    checkVal("add_busy", 64'(mdIf.md_busy), 64'h1);
    checkVal("add_nostall", 64'(mdIf.E_md_stall), 64'h0);
    checkVal("add_result", 64'(mdIf.E_md_result), 64'h0);
    stepClk();
    setIns(F_MFHI, 32'h0, 32'h0, 1'b0);
    #1;
    checkVal("mfhi_stall", 64'(mdIf.E_md_stall), 64'h1);
    cyc = 0;
    while (mdIf.md_busy && cyc < 100) begin
      cyc++;
      stepClk();
    end
    checkVal("mfhi_remaincyc", 64'(cyc), 64'd32);
    checkVal("mfhi_result", 64'(mdIf.E_md_result), 64'(exp[63:32]));

    // Held MULT must not start; release gives exactly one window
    setIns(F_MULT, 32'd7, 32'hFFFFFFF7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      stepClk();
      checkVal("hold_nobusy", 64'(mdIf.md_busy), 64'h0);
    end
    mdIf.E_hold = 1'b0;
    stepClk();
    setIns(F_ADD, 32'h0, 32'h0, 1'b0);
    cyc = 0;
    while (mdIf.md_busy && cyc < 100) begin
      cyc++;
      stepClk();
    end
    checkVal("hold_busycyc", 64'(cyc), 64'd33);
    checkVal("hold_hilo", {mdIf.HI, mdIf.LO}, 64'hFFFFFFFF_FFFFFFC1);
    for (int i = 0; i < 3; i++) begin
      stepClk();
      checkVal("hold_single", 64'(mdIf.md_busy), 64'h0);
    end

    // MTHI/MTLO, including a held MTLO that must not write
    setIns(F_MTHI, 32'h00001234, 32'h0, 1'b0);
    stepClk();
    checkVal("mthi", 64'(mdIf.HI), 64'h1234);
    setIns(F_MTLO, 32'hCAFEF00D, 32'h0, 1'b1);
    stepClk();
    checkVal("mtlo_held", 64'(mdIf.LO), 64'hFFFFFFC1);
    mdIf.E_hold = 1'b0;
    stepClk();
    checkVal("mtlo", 64'(mdIf.LO), 64'hCAFEF00D);
    setIns(F_ADD, 32'h0, 32'h0, 1'b0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      fn = fnTab[$urandom_range(3, 0)];
      a  = $urandom;
      case ($urandom_range(7, 0))
        0:       b = 32'h0;
        1:       b = $urandom_range(15, 1);
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(7, 0) == 0) a = 32'h80000000;
      exp = refOp(fn, a, b);
      runMd($sformatf("rand%0d_f%0h", n, fn), fn, a, b, exp);
      readBack($sformatf("rand%0d", n), exp);
    end

    // Reset in the middle of a DIV aborts it
    setIns(F_DIV, 32'h7FFFFFFF, 32'd3, 1'b0);
    stepClk();
    setIns(F_ADD, 32'h0, 32'h0, 1'b0);
    repeat (10) stepClk();
    checkVal("abort_busy_pre", 64'(mdIf.md_busy), 64'h1);
    rst_n = 1'b0;
    #1;
    checkVal("abort_busy", 64'(mdIf.md_busy), 64'h0);
    checkVal("abort_hilo", {mdIf.HI, mdIf.LO}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stepClk();
    checkVal("abort_idle", 64'(mdIf.md_busy), 64'h0);
    runMd("post_rst_mult", F_MULT, 32'd2, 32'd3, 64'h00000000_00000006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
